// File: rtl/sparc_mem_responder_if.sv
// MOV/MOC request/response bundle between an MPU-side initiator
// and the memory responder.
interface sparc_mem_responder_if #(
   parameter int ADDR_W = 9
);
   logic              MOV;
   logic              RW;
   logic [1:0]        Type;
   logic [ADDR_W-1:0] Address;
   logic [31:0]       DataIn;
   logic [31:0]       DataOut;
   logic              MOC;
   logic              MAE;

   modport master (
      output MOV, RW, Type, Address, DataIn,
      input  DataOut, MOC, MAE
   );

   modport slave (
      input  MOV, RW, Type, Address, DataIn,
      output DataOut, MOC, MAE
   );
endinterface

// File: rtl/sparc_mem_responder.sv
// Registered big-endian byte RAM answering MOV with MOC after WAIT_STATES.
// Define MISALIGN_TRAP_EN to flag misaligned halfword/word requests on MAE.
module sparc_mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DEPTH       = 512,
   parameter int WAIT_STATES = 2
) (
   input logic                  Clk,
   input logic                  Clr,
   sparc_mem_responder_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            st;
   logic [3:0]        cnt;
   logic              rw_q;
   logic [1:0]        typ_q;
   logic [ADDR_W-1:0] adr_q;
   logic [31:0]       din_q;

   logic [7:0]        mem [DEPTH];

   logic [ADDR_W-1:0] abase;
   logic [IW-1:0]     i0, i1, i2, i3;
   logic              mis;
   logic              fire;
   logic              we;
   logic [31:0]       rdata;

   function automatic logic [IW-1:0] idx(
      input logic [ADDR_W-1:0] a,
      input int                k
   );
      return IW'((int'(a) + k) % DEPTH);
   endfunction

   always_comb begin
      abase = adr_q;
      mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis = (typ_q == 2'b01 && adr_q[0]) ||
            (typ_q[1] && adr_q[1:0] != 2'b00);
`else
      // forced alignment keeps multi-byte accesses from wrapping
      if (typ_q == 2'b01)
         abase[0] = 1'b0;
      else if (typ_q[1])
         abase[1:0] = 2'b00;
`endif
   end

   assign i0 = idx(abase, 0);
   assign i1 = idx(abase, 1);
   assign i2 = idx(abase, 2);
   assign i3 = idx(abase, 3);

   assign fire = (st == WAIT) && (cnt == 4'd0);
   assign we   = fire && !rw_q && !mis && !Clr;

   always_comb begin
      rdata = 32'h0;
      unique case (1'b1)
         (typ_q == 2'b00): rdata = {24'h0, mem[i0]};
         (typ_q == 2'b01): rdata = {16'h0, mem[i0], mem[i1]};
         default:          rdata = {mem[i0], mem[i1], mem[i2], mem[i3]};
      endcase
   end

   // array is never reset so benches can preload it directly
   always_ff @(posedge Clk) begin
      if (we) begin
         unique case (1'b1)
            (typ_q == 2'b00): begin
               mem[i0] <= din_q[7:0];
            end
            (typ_q == 2'b01): begin
               mem[i0] <= din_q[15:8];
               mem[i1] <= din_q[7:0];
            end
            default: begin
               mem[i0] <= din_q[31:24];
               mem[i1] <= din_q[23:16];
               mem[i2] <= din_q[15:8];
               mem[i3] <= din_q[7:0];
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         st          <= IDLE;
         cnt         <= 4'd0;
         rw_q        <= 1'b0;
         typ_q       <= 2'b00;
         adr_q       <= '0;
         din_q       <= 32'h0;
         bus.MOC     <= 1'b0;
         bus.MAE     <= 1'b0;
         bus.DataOut <= 32'h0;
      end else begin
         unique case (st)
            IDLE: begin
               if (bus.MOV) begin
                  rw_q  <= bus.RW;
                  typ_q <= bus.Type;
                  adr_q <= bus.Address;
                  din_q <= bus.DataIn;
                  cnt   <= 4'(WAIT_STATES);
                  st    <= WAIT;
               end
            end
            WAIT: begin
               if (fire) begin
                  bus.MOC <= 1'b1;
                  bus.MAE <= mis;
                  if (rw_q && !mis)
                     bus.DataOut <= rdata;
                  st <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               // MOV must be seen low before another capture
               if (!bus.MOV) begin
                  bus.MOC <= 1'b0;
                  bus.MAE <= 1'b0;
                  st      <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sparc_mem_responder.sv
// Bench for sparc_mem_responder: two instances (2 and 0 wait states)
// checked every cycle against a deadline-based transaction model.
module tb_sparc_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  clr, mov, rw, moc, mae;
   logic [1:0]  typ  [2];
   logic [8:0]  adr  [2];
   logic [31:0] din  [2];
   logic [31:0] dout [2];

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   sparc_mem_responder_if #(.ADDR_W(9)) b0 ();
   sparc_mem_responder_if #(.ADDR_W(9)) b1 ();

   assign b0.MOV     = mov[0];
   assign b0.RW      = rw[0];
   assign b0.Type    = typ[0];
   assign b0.Address = adr[0];
   assign b0.DataIn  = din[0];
   assign moc[0]     = b0.MOC;
   assign mae[0]     = b0.MAE;
   assign dout[0]    = b0.DataOut;

   assign b1.MOV     = mov[1];
   assign b1.RW      = rw[1];
   assign b1.Type    = typ[1];
   assign b1.Address = adr[1];
   assign b1.DataIn  = din[1];
   assign moc[1]     = b1.MOC;
   assign mae[1]     = b1.MAE;
   assign dout[1]    = b1.DataOut;

   sparc_mem_responder #(
      .ADDR_W(9), .DEPTH(512), .WAIT_STATES(2)
   ) dut0 (
      .Clk(clk), .Clr(clr[0]), .bus(b0)
   );

   sparc_mem_responder #(
      .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)
   ) dut1 (
      .Clk(clk), .Clr(clr[1]), .bus(b1)
   );

   // model: a captured request completes at capture edge + W + 1
   int          wst     [2] = '{2, 0};
   int          edges   [2];
   int          due     [2];
   int          acc_cnt [2];
   bit          m_busy  [2];
   bit          m_moc   [2];
   bit          m_mae   [2];
   logic [31:0] m_dout  [2];
   bit          m_rw    [2];
   int          m_typ   [2];
   int          m_adr   [2];
   logic [31:0] m_din   [2];
   logic [7:0]  mm      [2][512];

   task automatic check(string nm, int k,
                        logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] got %h expected %h at %0t",
                  nm, k, act, exp, $time);
      end
   endtask

   task automatic access(int k);
      int n;
      int base;
      logic [31:0] v;
      n    = (m_typ[k] == 0) ? 1 : (m_typ[k] == 1) ? 2 : 4;
      base = m_adr[k];
`ifdef MISALIGN_TRAP_EN
      if (base % n != 0) begin
         m_mae[k] = 1'b1;
         return;
      end
`else
      base = base - base % n;
`endif
      acc_cnt[k]++;
      if (m_rw[k]) begin
         v = 32'h0;
         for (int i = 0; i < n; i++)
            v = (v << 8) | 32'(mm[k][(base + i) % 512]);
         m_dout[k] = v;
      end else begin
         for (int i = 0; i < n; i++)
            mm[k][(base + i) % 512] = 8'(m_din[k] >> (8 * (n - 1 - i)));
      end
   endtask

   task automatic step(int k);
      if (clr[k]) begin
         m_busy[k] = 1'b0;
         m_moc[k]  = 1'b0;
         m_mae[k]  = 1'b0;
         m_dout[k] = 32'h0;
         return;
      end
      edges[k]++;
      if (m_busy[k]) begin
         if (edges[k] == due[k]) begin
            m_mae[k] = 1'b0;
            access(k);
            m_busy[k] = 1'b0;
            m_moc[k]  = 1'b1;
         end
      end else if (m_moc[k]) begin
         if (!mov[k]) begin
            m_moc[k] = 1'b0;
            m_mae[k] = 1'b0;
         end
      end else if (mov[k]) begin
         m_rw[k]   = rw[k];
         m_typ[k]  = int'(typ[k]);
         m_adr[k]  = int'(adr[k]);
         m_din[k]  = din[k];
         m_busy[k] = 1'b1;
         due[k]    = edges[k] + wst[k] + 1;
      end
   endtask

   always @(posedge clk or posedge clr[0]) step(0);
   always @(posedge clk or posedge clr[1]) step(1);

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check("moc", k, 32'(moc[k]), 32'(m_moc[k]));
            check("mae", k, 32'(mae[k]), 32'(m_mae[k]));
            check("dout", k, dout[k], m_dout[k]);
         end
      end
   end

   task automatic drive(int k, bit r, logic [1:0] t,
                        logic [8:0] a, logic [31:0] d);
      mov[k] = 1'b1;
      rw[k]  = r;
      typ[k] = t;
      adr[k] = a;
      din[k] = d;
   endtask

   task automatic wait_moc(int k, bit lvl, int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (moc[k] == lvl) ok = 1'b1;
      end
      if (!ok) check("timeout", k, 32'(moc[k]), 32'(lvl));
   endtask

   task automatic xfer(int k, bit r, logic [1:0] t,
                       logic [8:0] a, logic [31:0] d,
                       output logic [31:0] dv, output logic mv);
      drive(k, r, t, a, d);
      wait_moc(k, 1'b1, 40);
      mv = mae[k];
      #1 mov[k] = 1'b0;
      wait_moc(k, 1'b0, 5);
      #1 dv = dout[k];
   endtask

   logic [31:0] v;
   logic        m;
   int          a0;
   logic [31:0] bexp [4] = '{32'hDE, 32'hAD, 32'hBE, 32'hEF};

   initial begin
      clr = 2'b11;
      mov = 2'b00;
      rw  = 2'b00;
      for (int k = 0; k < 2; k++) begin
         typ[k] = 2'b00;
         adr[k] = 9'h0;
         din[k] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst_moc", k, 32'(moc[k]), 32'h0);
         check("rst_mae", k, 32'(mae[k]), 32'h0);
         check("rst_dout", k, dout[k], 32'h0);
      end
      #1 clr = 2'b00;
      chk_en = 1'b1;
      @(negedge clk);
      #1;

      xfer(0, 1'b0, 2'b10, 9'h004, 32'hDEADBEEF, v, m);
      for (int i = 0; i < 4; i++) begin
         xfer(0, 1'b1, 2'b00, 9'(4 + i), 32'h0, v, m);
         check("byte_rd", i, v, bexp[i]);
      end
      xfer(0, 1'b1, 2'b01, 9'h006, 32'h0, v, m);
      check("half_rd", 0, v, 32'h0000BEEF);
      xfer(0, 1'b0, 2'b00, 9'h1FF, 32'h0000005A, v, m);
      xfer(0, 1'b1, 2'b00, 9'h1FF, 32'h0, v, m);
      check("top_byte", 0, v, 32'h0000005A);

      a0 = acc_cnt[0];
      drive(0, 1'b1, 2'b10, 9'h004, 32'h0);
      for (int e = 0; e < 3; e++) begin
         @(negedge clk);
         check("lat_lo", e, 32'(moc[0]), 32'h0);
      end
      @(negedge clk);
      check("lat_hi", 0, 32'(moc[0]), 32'h1);
      check("lat_dout", 0, dout[0], 32'hDEADBEEF);
      repeat (5) begin
         @(negedge clk);
         check("hold_moc", 0, 32'(moc[0]), 32'h1);
      end
      check("one_access", 0, 32'(acc_cnt[0] - a0), 32'h1);
      #1 mov[0] = 1'b0;
      @(negedge clk);
      check("moc_fall", 0, 32'(moc[0]), 32'h0);
      #1;

      drive(0, 1'b1, 2'b00, 9'h1FF, 32'h0);
      @(negedge clk);
      #1 mov[0] = 1'b0;
      wait_moc(0, 1'b1, 10);
      check("drop_dout", 0, dout[0], 32'h0000005A);
      @(negedge clk);
      check("drop_pulse", 0, 32'(moc[0]), 32'h0);
      #1;

      xfer(0, 1'b0, 2'b10, 9'h005, 32'h12345678, v, m);
`ifdef MISALIGN_TRAP_EN
      check("mis_mae", 0, 32'(m), 32'h1);
      xfer(0, 1'b1, 2'b10, 9'h004, 32'h0, v, m);
      check("mis_keep", 0, v, 32'hDEADBEEF);
`else
      check("mis_mae", 0, 32'(m), 32'h0);
      xfer(0, 1'b1, 2'b10, 9'h004, 32'h0, v, m);
      check("mis_align", 0, v, 32'h12345678);
`endif

      xfer(0, 1'b0, 2'b10, 9'h010, 32'h01020304, v, m);
      xfer(0, 1'b1, 2'b10, 9'h010, 32'h0, v, m);
      drive(0, 1'b0, 2'b10, 9'h010, 32'hCAFEF00D);
      @(negedge clk);
      #1;
      clr[0] = 1'b1;
      mov[0] = 1'b0;
      #1;
      check("clr_moc", 0, 32'(moc[0]), 32'h0);
      check("clr_dout", 0, dout[0], 32'h0);
      @(negedge clk);
      #1 clr[0] = 1'b0;
      @(negedge clk);
      #1;
      xfer(0, 1'b1, 2'b10, 9'h010, 32'h0, v, m);
      check("clr_keep", 0, v, 32'h01020304);

      xfer(1, 1'b0, 2'b10, 9'h020, 32'hA5A51234, v, m);
      a0 = acc_cnt[1];
      drive(1, 1'b1, 2'b10, 9'h020, 32'h0);
      @(negedge clk);
      check("b2b_cap", 0, 32'(moc[1]), 32'h0);
      @(negedge clk);
      check("b2b_rd", 1, 32'(moc[1]), 32'h1);
      check("b2b_rdat", 1, dout[1], 32'hA5A51234);
      #1 mov[1] = 1'b0;
      @(negedge clk);
      check("b2b_low", 1, 32'(moc[1]), 32'h0);
      #1 drive(1, 1'b0, 2'b10, 9'h024, 32'h0BADF00D);
      @(negedge clk);
      check("b2b_cap2", 1, 32'(moc[1]), 32'h0);
      @(negedge clk);
      check("b2b_wr", 1, 32'(moc[1]), 32'h1);
      #1 mov[1] = 1'b0;
      @(negedge clk);
      check("b2b_low2", 1, 32'(moc[1]), 32'h0);
      check("b2b_count", 1, 32'(acc_cnt[1] - a0), 32'h2);
      #1;
      xfer(1, 1'b1, 2'b10, 9'h024, 32'h0, v, m);
      check("b2b_word", 1, v, 32'h0BADF00D);
      xfer(1, 1'b1, 2'b01, 9'h026, 32'h0, v, m);
      check("b2b_half", 1, v, 32'h0000F00D);

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sparc_mem_responder.md
Name: sparc_mem_responder

Overview:
- Memory-side responder for the MOV/MOC handshake that the SPARC MPU datapath (MAR/MDR) and the preload/dump benches drive as initiator.
- Byte-addressed, big-endian RAM with configurable wait states.
- Supports byte, halfword and word transfers on a 32-bit data path.
- Replaces the zero-latency combinational RAM model with a registered, cycle-accurate responder, so control-unit wait loops on MOC are exercised.

Parameters:
ADDR_W, 9, address width in bits.
DEPTH, 512, number of bytes stored; addresses index modulo DEPTH.
WAIT_STATES, 2, extra cycles between request capture and access completion (0..15).

Ports:
Clk  input  1  system clock, all state updates on the rising edge.
Clr  input  1  asynchronous, active-high reset.
MOV  input  1  memory operation valid (request), level-held by initiator until MOC seen.
RW  input  1  1 = read, 0 = write.
Type  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
Address  input  ADDR_W  byte address.
DataIn  input  32  write data, right-justified for byte/halfword.
DataOut  output  32  read data, zero-extended, right-justified.
MOC  output  1  memory operation complete.
MAE  output  1  misaligned access error (driven 0 when MISALIGN_TRAP_EN is undefined).

Behaviour:
- Reset (Clr=1, asynchronous):
  - State returns to IDLE, wait counter cleared.
  - MOC=0, MAE=0, DataOut=32'h0.
  - RAM array contents are NOT cleared.
  - A pending write aborted by reset never modifies the array.
- State machine, states IDLE, WAIT, DONE:
  - IDLE: at an edge sampling MOV=1, latch Address, Type, RW, DataIn into request registers. Load counter with WAIT_STATES and go to WAIT. Inputs are not re-sampled until the next IDLE.
  - WAIT: counter decrements each edge. At the edge where the counter is 0, perform the access, set MOC=1 (registered) and go to DONE.
  - Latency: capture at edge E0 gives MOC=1 after edge E0+WAIT_STATES+1. WAIT_STATES=0 gives MOC one edge after capture.
  - DONE: MOC and DataOut hold stable while MOV=1. At the edge sampling MOV=0, MOC falls to 0 and the block returns to IDLE. DataOut holds its last value until the next read completes.
  - A new request requires MOV to be sampled 0 at least once; MOV held high across DONE never triggers a second access.
- MOV dropped during WAIT: the request still completes; MOC pulses for one cycle at completion, then DONE sees MOV=0 and returns to IDLE.
- Big-endian layout, A = latched address:
  - Word: mem[A]=D[31:24], mem[A+1]=D[23:16], mem[A+2]=D[15:8], mem[A+3]=D[7:0].
  - Halfword: mem[A]=D[15:8], mem[A+1]=D[7:0].
  - Byte: mem[A]=D[7:0].
  - Reads mirror these layouts, unused upper bits = 0.
- Alignment when MISALIGN_TRAP_EN is undefined: halfword ignores A[0]; word/11 ignore A[1:0]. This forced alignment keeps multi-byte accesses inside DEPTH with no wrap.
- Writes do not change DataOut.
- Array is a plain reg array, accessible hierarchically so benches can preload and dump it directly.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Halfword with A[0]=1, or word/11 with A[1:0]!=0, is misaligned.
  - A misaligned request completes with normal latency and MOC=1, plus MAE=1 for the same cycles as MOC.
  - No array write occurs; DataOut is unchanged.
  - MAE clears together with MOC.
- Undefined: MAE tied 0; forced alignment as in Behaviour.

Test Plan:
- Word write 32'hDEADBEEF at 0x004, then byte reads 0x004..0x007 -> DataOut 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF.
- WAIT_STATES=2, read with MOV rising before edge 0 -> MOC=0 after edges 0–2, MOC=1 after edge 3. MOV held high 5 more cycles -> MOC stays 1, exactly one access. MOV low -> MOC=0 next edge.
- Halfword read at 0x006 after the first test -> 0x0000BEEF. Byte write 8'h5A at 0x1FF then read -> 0x0000005A.
- Word write 32'h12345678 at 0x005:
  - Macro defined -> MAE=1 with MOC, word at 0x004 still DEADBEEF.
  - Macro undefined -> MAE=0, word read at 0x004 returns 0x12345678.
- Clr pulsed during WAIT of a write 32'hCAFEF00D to 0x010 -> MOC=0 and DataOut=0 immediately. Subsequent read of 0x010 returns the prior contents.
- WAIT_STATES=0 back-to-back: read, MOV low one cycle, write -> MOC high one edge after each capture, no lost or duplicated access.
